rd_pipe_skid_reg: RTL and testbench

// - Parametrised elastic pipeline register for the cache-read return path (cache result + read address).
// - Sits between cache read stage and register-write/forward stage.
// - Adds valid/ready backpressure, 2-entry skid for full throughput, synchronous flush and occupancy/drop telemetry.
// - Generalises the fixed 109/32-bit always-load stage register.

---
 rtl/rd_pipe_pkg.sv | 16 +
 rtl/rd_pipe_entry.sv | 37 +++
 rtl/rd_pipe_skid_reg.sv | 175 +++++++++++++++++
 tb/tb_rd_pipe_skid_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_pipe_pkg.sv
// Shared types and default widths for the cache-read return pipeline register.
//   rd_state_e : occupancy state of the elastic stage (EMPTY/BUSY/FULL)
//   RD_DATA_W  : default cache result payload width
//   RD_ADDR_W  : default read address width
package rd_pipe_pkg;

    localparam int unsigned RD_DATA_W = 109;
    localparam int unsigned RD_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } rd_state_e;

endpackage : rd_pipe_pkg

// File: rtl/rd_pipe_entry.sv
// One payload slot {data, addr} of the read return pipeline.
// Ports:
//   CLK, RESET       : clock, asynchronous active-high reset (slot -> 0)
//   load, clear      : load d_* / clear to 0 (clear wins)
//   d_data, d_addr   : next payload
//   q_data, q_addr   : held payload
module rd_pipe_entry
    import rd_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = RD_DATA_W,
    parameter int unsigned ADDR_W = RD_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] q_data,
    output logic [ADDR_W-1:0] q_addr
);

    // Payload register; clear keeps empty slots at 0 so nothing stale leaks out.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_data <= '0;
            q_addr <= '0;
        end else if (clear) begin
            q_data <= '0;
            q_addr <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_addr <= d_addr;
        end
    end

endmodule : rd_pipe_entry

// File: rtl/rd_pipe_skid_reg.sv
// Elastic pipeline register for the cache-read return path (cache result + address).
// Ports:
//   CLK, RESET           : clock, asynchronous active-high reset
//   flush                : synchronous discard of all held entries
//   in_valid/in_ready    : upstream handshake, in_data/in_addr payload
//   out_valid/out_ready  : downstream handshake, out_data/out_addr head payload (0 when empty)
//   occupancy            : held entries (0..2)
//   drop_cnt             : saturating count of valid entries discarded by flush
module rd_pipe_skid_reg
    import rd_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = RD_DATA_W,
    parameter int unsigned ADDR_W  = RD_ADDR_W,
    parameter bit          SKID_EN = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    rd_state_e state_q;
    rd_state_e state_d;

    logic in_fire;
    logic out_fire;

    logic main_load;
    logic main_clear;
    logic main_sel_skid;
    logic skid_load;
    logic skid_clear;

    logic [DATA_W-1:0] main_d_data;
    logic [ADDR_W-1:0] main_d_addr;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_addr;

    logic [OCC_W-1:0] drop_add;
    logic [SUM_W-1:0] drop_sum;

    // Handshake decode; with the skid, in_ready depends on state only.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = SKID_EN ? (state_q != ST_FULL) : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Occupancy follows the state register directly.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and slot control; flush overrides all normal movement.
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_BUSY;
                        main_load = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID_EN) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d       = ST_BUSY;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Entries leaving downstream in the flush cycle are delivered, not dropped.
    assign drop_add = occupancy - OCC_W'(out_fire);
    assign drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_add);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= (drop_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(drop_sum);
        end
    end

    // Main slot refills from the skid when draining FULL, otherwise from the input.
    assign main_d_data = main_sel_skid ? skid_data : in_data;
    assign main_d_addr = main_sel_skid ? skid_addr : in_addr;

    rd_pipe_entry #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_main (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_addr (main_d_addr),
        .q_data (out_data),
        .q_addr (out_addr)
    );

    if (SKID_EN) begin : g_skid
        rd_pipe_entry #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_skid (
            .CLK    (CLK),
            .RESET  (RESET),
            .load   (skid_load),
            .clear  (skid_clear),
            .d_data (in_data),
            .d_addr (in_addr),
            .q_data (skid_data),
            .q_addr (skid_addr)
        );
    end else begin : g_no_skid
        logic unused_skid_ctrl;
        assign unused_skid_ctrl = skid_load ^ skid_clear;
        assign skid_data = '0;
        assign skid_addr = '0;
    end

endmodule : rd_pipe_skid_reg

// File: tb/tb_rd_pipe_skid_reg.sv
// Directed bench: default skid stage, a CNT_W=2 copy sharing its stimulus,
// and a SKID_EN=0 copy with its own stimulus.
module tb_rd_pipe_skid_reg;

    localparam int unsigned DW = 109;
    localparam int unsigned AW = 32;

    logic          CLK;
    logic          RESET;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          out_ready;

    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [1:0]    occupancy;
    logic [7:0]    drop_cnt;

    logic          c2_in_ready;
    logic          c2_out_valid;
    logic [DW-1:0] c2_out_data;
    logic [AW-1:0] c2_out_addr;
    logic [1:0]    c2_occupancy;
    logic [1:0]    c2_drop_cnt;

    logic          ns_flush;
    logic          ns_in_valid;
    logic [DW-1:0] ns_in_data;
    logic [AW-1:0] ns_in_addr;
    logic          ns_out_ready;
    logic          ns_in_ready;
    logic          ns_out_valid;
    logic [DW-1:0] ns_out_data;
    logic [AW-1:0] ns_out_addr;
    logic [1:0]    ns_occupancy;
    logic [7:0]    ns_drop_cnt;

    int checks = 0;
    int passed = 0;

    rd_pipe_skid_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(1'b1), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    rd_pipe_skid_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(1'b1), .CNT_W(2)) dut_c2 (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .in_valid(in_valid), .in_ready(c2_in_ready), .in_data(in_data), .in_addr(in_addr),
        .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data), .out_addr(c2_out_addr),
        .occupancy(c2_occupancy), .drop_cnt(c2_drop_cnt)
    );

    rd_pipe_skid_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(1'b0), .CNT_W(8)) dut_ns (
        .CLK(CLK), .RESET(RESET), .flush(ns_flush),
        .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data), .in_addr(ns_in_addr),
        .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data), .out_addr(ns_out_addr),
        .occupancy(ns_occupancy), .drop_cnt(ns_drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stimulus only: push two entries with out_ready low so the skid stage ends FULL.
    task automatic fill_full(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = a0;
        in_data   = DW'(a0) + DW'(16'hD000);
        tick();
        in_addr   = a1;
        in_data   = DW'(a1) + DW'(16'hD000);
        tick();
        in_valid  = 1'b0;
        in_data   = 'x;
        in_addr   = 'x;
    endtask

    task automatic test_reset();
        RESET = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = 1'b0;
        ns_flush = 1'b0; ns_in_valid = 1'b0; ns_in_data = '0; ns_in_addr = '0; ns_out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (out_data !== '0 || out_addr !== '0) $display("FAIL reset_payload: got %h/%h expected 0/0", out_data, out_addr); else passed++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 109'h1ABC;
        in_addr   = 32'h8000_0010;
        tick();
        in_valid  = 1'b0;
        in_data   = 'x;
        in_addr   = 'x;
        checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_data !== 109'h1ABC) $display("FAIL single_out_data: got %h expected 1abc", out_data); else passed++;
        checks++; if (out_addr !== 32'h8000_0010) $display("FAIL single_out_addr: got %h expected 80000010", out_addr); else passed++;
        checks++; if (occupancy !== 2'd1) $display("FAIL single_occ1: got %0d expected 1", occupancy); else passed++;
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL single_drain: got occ %0d valid %b expected 0 0", occupancy, out_valid); else passed++;
        checks++; if (out_data !== '0 || out_addr !== '0) $display("FAIL single_empty_payload: got %h/%h expected 0/0", out_data, out_addr); else passed++;
    endtask

    task automatic test_skid();
        fill_full(32'h10, 32'h14);
        checks++; if (occupancy !== 2'd2) $display("FAIL skid_occupancy: got %0d expected 2", occupancy); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL skid_in_ready: got %b expected 0", in_ready); else passed++;
        tick();
        checks++; if (out_addr !== 32'h10 || out_data !== 109'hD010) $display("FAIL skid_hold_a: got %h/%h expected 10/d010", out_addr, out_data); else passed++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_addr !== 32'h14 || out_data !== 109'hD014) $display("FAIL skid_then_b: got %h/%h expected 14/d014", out_addr, out_data); else passed++;
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) $display("FAIL skid_busy: got occ %0d rdy %b expected 1 1", occupancy, in_ready); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL skid_drained: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_addr = AW'(i * 4);
            in_data = DW'(i) + DW'(12'h100);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_addr !== AW'(i * 4) || in_ready !== 1'b1)
                $display("FAIL b2b_beat%0d: got valid %b addr %h rdy %b expected 1 %h 1", i, out_valid, out_addr, in_ready, i * 4);
            else passed++;
        end
        in_valid = 1'b0;
        in_data  = 'x;
        in_addr  = 'x;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL b2b_end: got valid %b occ %0d expected 0 0", out_valid, occupancy); else passed++;
    endtask

    task automatic test_flush_full();
        fill_full(32'h20, 32'h24);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 32'h28;
        in_data  = 109'hD028;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL flush_empty: got valid %b occ %0d expected 0 0", out_valid, occupancy); else passed++;
        checks++; if (out_data !== '0 || out_addr !== '0) $display("FAIL flush_payload: got %h/%h expected 0/0", out_data, out_addr); else passed++;
        checks++; if (drop_cnt !== 8'd2) $display("FAIL flush_drop_cnt: got %0d expected 2", drop_cnt); else passed++;
        checks++; if (c2_drop_cnt !== 2'd2) $display("FAIL flush_drop_cnt_c2: got %0d expected 2", c2_drop_cnt); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_input_lost: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_saturate();
        fill_full(32'h30, 32'h34);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (c2_drop_cnt !== 2'd3) $display("FAIL sat_c2_first: got %0d expected 3", c2_drop_cnt); else passed++;
        checks++; if (drop_cnt !== 8'd4) $display("FAIL sat_main_4: got %0d expected 4", drop_cnt); else passed++;
        fill_full(32'h38, 32'h3C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (c2_drop_cnt !== 2'd3) $display("FAIL sat_c2_hold: got %0d expected 3", c2_drop_cnt); else passed++;
        checks++; if (drop_cnt !== 8'd6) $display("FAIL sat_main_6: got %0d expected 6", drop_cnt); else passed++;
        // Flush while the head leaves downstream: only the skid entry is dropped.
        fill_full(32'h40, 32'h44);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        checks++; if (drop_cnt !== 8'd7) $display("FAIL flush_with_out_fire: got %0d expected 7", drop_cnt); else passed++;
    endtask

    task automatic test_no_skid();
        int exp_rdy [6] = '{1, 0, 1, 0, 1, 0};
        int exp_adr [6] = '{0, 0, 4, 4, 8, 8};
        logic [AW-1:0] next_addr;
        next_addr   = '0;
        ns_in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ns_out_ready = (k % 2 == 0);
            ns_in_addr   = next_addr;
            ns_in_data   = DW'(next_addr) + DW'(16'hE000);
            #1;
            checks++;
            if (ns_in_ready !== 1'(exp_rdy[k])) $display("FAIL ns_in_ready_%0d: got %b expected %0d", k, ns_in_ready, exp_rdy[k]);
            else passed++;
            if (exp_rdy[k] != 0) next_addr = next_addr + AW'(4);
            tick();
            checks++;
            if (ns_out_valid !== 1'b1 || ns_out_addr !== AW'(exp_adr[k]) || ns_occupancy !== 2'd1)
                $display("FAIL ns_head_%0d: got valid %b addr %h occ %0d expected 1 %h 1", k, ns_out_valid, ns_out_addr, ns_occupancy, exp_adr[k]);
            else passed++;
        end
        ns_in_valid  = 1'b0;
        ns_out_ready = 1'b1;
        tick();
        checks++; if (ns_out_valid !== 1'b0 || ns_occupancy !== 2'd0) $display("FAIL ns_drain: got valid %b occ %0d expected 0 0", ns_out_valid, ns_occupancy); else passed++;
        ns_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_full(32'h50, 32'h54);
        checks++; if (occupancy !== 2'd2) $display("FAIL rmid_full: got %0d expected 2", occupancy); else passed++;
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_addr !== '0 || out_data !== '0) $display("FAIL rmid_async_out: got %b %h %h expected 0 0 0", out_valid, out_addr, out_data); else passed++;
        checks++; if (drop_cnt !== 8'd0 || occupancy !== 2'd0) $display("FAIL rmid_counters: got drop %0d occ %0d expected 0 0", drop_cnt, occupancy); else passed++;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL rmid_release: got rdy %b valid %b expected 1 0", in_ready, out_valid); else passed++;
        tick();
        checks++; if (in_ready !== 1'b1 || drop_cnt !== 8'd0) $display("FAIL rmid_after: got rdy %b drop %0d expected 1 0", in_ready, drop_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_flush_full();
        test_saturate();
        test_no_skid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_rd_pipe_skid_reg
